piso_frame_tx: RTL and testbench
================================

# piso_frame_tx

Parallel-in, serial-out frame transmitter that generates the single-bit serial stream consumed by the `siso` shift-register chain on its `s_in` input. It accepts a WIDTH-bit word over a valid/ready handshake and emits one framed bit per clock: a start bit, the data bits, an optional even-parity bit and a stop bit. Back-to-back frames are supported without idle gaps.

## Interface
- `WIDTH`, 8: data bits per frame; must be at least 2.
- `LSB_FIRST`, 1: 1 sends data bit 0 first; 0 sends bit WIDTH-1 first.
- `PARITY_EN`, 1: 1 inserts an even-parity bit after the data; 0 omits it.

- `clk`  in  1  single clock; all state changes on its rising edge.
- `clear`  in  1  asynchronous, active-high reset.
- `data_in`  in  WIDTH  word to transmit; sampled only on handshake.
- `load_valid`  in  1  `data_in` is valid.
- `load_ready`  out  1  block can accept a word this cycle.
- `s_out`  out  1  serial line; drives `siso.s_in`.
- `busy`  out  1  a frame is in progress, from START through STOP.
- `done`  out  1  one-cycle pulse during the stop-bit cycle.

## Operation
- Line levels: idle 0, start bit 1, stop bit 0.
- Parity bit: XOR of all data bits (even parity).
- FSM states:
  - IDLE: `s_out`=0. On handshake, go to START.
  - START: `s_out`=1, then go to DATA.
  - DATA: stays WIDTH cycles, shifting one bit per cycle. Then go to PARITY if `PARITY_EN`, else STOP.
  - PARITY: `s_out`=parity bit, then go to STOP.
  - STOP: `s_out`=0. On handshake go to START, else go to IDLE.
- Handshake:
  - Occurs on a rising edge with `load_valid && load_ready`.
  - `load_ready` = (IDLE or STOP) and not `clear`.
  - `data_in` and its parity are captured into an internal shift register on the handshake edge.
  - Later changes to `data_in` do not affect the frame in flight.
  - `load_valid` while in START, DATA or PARITY is ignored, not queued.
- Bit counter: $clog2(WIDTH) bits. Loads 0 on entry to DATA; DATA exits when the counter reaches WIDTH-1. No wrap beyond that.
- `s_out` is a registered output, so it carries no combinational path from the inputs.
- `busy` = state != IDLE.
- `done` = state == STOP.

## Timing
- Reset values while `clear`=1: state IDLE, `s_out`=0, `busy`=0, `done`=0, `load_ready`=0, shift register and counter at 0.
- Reset takes effect immediately, including mid-frame. The remainder of the frame is abandoned and nothing resumes after `clear` deasserts.
- After `clear` deasserts, `load_ready`=1 in the same cycle (state is IDLE).
- Latency: handshake at edge k gives `s_out`=start bit during cycle k+1. The first data bit follows in cycle k+2.
- Frame length: 1 + WIDTH + PARITY_EN + 1 cycles, which is 11 for the defaults.
- Back-to-back: a handshake during STOP puts the next start bit in the cycle immediately after the stop bit. Frame period equals frame length.
- If `clear` and a handshake coincide, `clear` wins and no word is accepted.

## Structure
- Shared package `piso_pkg` holds:
  - the state enum (IDLE, START, DATA, PARITY, STOP);
  - constants IDLE_LEVEL=0, START_LEVEL=1, STOP_LEVEL=0.
- Single module. The shift register, counter and FSM are all internal, with no sub-module.
- Expected size: about 150 lines of RTL.

## Test plan
- Defaults, `data_in`=8'hA5, one handshake:
  - `s_out` over the 11 cycles after the handshake = 1, 1,0,1,0,0,1,0,1, 0, 0;
  - `done` high on cycle 11 only, then the line idles at 0.
- `LSB_FIRST`=0, `data_in`=8'h01:
  - `s_out` = 1, 0,0,0,0,0,0,0,1, 1 (parity), 0.
- `PARITY_EN`=0, `data_in`=8'hFF:
  - 10-cycle frame 1, 1×8, 0;
  - `busy` high for exactly 10 cycles.
- Back-to-back, 8'h0F then 8'hF0, `load_valid` held:
  - the second start bit immediately follows the first stop bit;
  - `load_ready` is high only in IDLE and STOP cycles.
- Mid-frame `data_in` change, plus `load_valid` held during DATA:
  - the transmitted bits match the word captured at the handshake;
  - no second handshake occurs until STOP.
- `clear` pulsed on the 4th data bit:
  - `s_out`=0, `busy`=0, `load_ready`=0 immediately;
  - after release, a new 8'h3C frame transmits correctly.

Source files
------------

// File: rtl/piso_pkg.sv
// Shared types and line levels for the framed serial transmitter.
package piso_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } state_e;

  localparam logic IDLE_LEVEL  = 1'b0;
  localparam logic START_LEVEL = 1'b1;
  localparam logic STOP_LEVEL  = 1'b0;

endpackage

// File: rtl/piso_frame_tx_if.sv
// Load handshake and serial-line bundle between a word source and piso_frame_tx.
interface piso_frame_tx_if #(
  parameter int unsigned WIDTH = 8
) ();

  logic [WIDTH-1:0] data_in;
  logic             load_valid;
  logic             load_ready;
  logic             s_out;
  logic             busy;
  logic             done;

  modport master (
    output data_in,
    output load_valid,
    input  load_ready,
    input  s_out,
    input  busy,
    input  done
  );

  modport slave (
    input  data_in,
    input  load_valid,
    output load_ready,
    output s_out,
    output busy,
    output done
  );

endinterface

// File: rtl/piso_frame_tx.sv
// Parallel-in serial-out framer: start bit, WIDTH data bits, optional even parity, stop bit.
module piso_frame_tx
  import piso_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter bit          LSB_FIRST = 1'b1,
  parameter bit          PARITY_EN = 1'b1
) (
  input logic            clk,
  input logic            clear,
  piso_frame_tx_if.slave bus
);

  localparam int unsigned        CntW    = $clog2(WIDTH);
  localparam logic [CntW-1:0]    CntLast = CntW'(WIDTH - 1);

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [WIDTH:0]  shreg_q, shreg_d;
  logic [WIDTH:0]  load_word;
  logic [WIDTH:0]  shifted;
  logic            out_bit;
  logic            s_out_q, s_out_d;
  logic            handshake;

  assign bus.load_ready = ((state_q == StIdle) || (state_q == StStop)) && !clear;
  assign handshake      = bus.load_valid && bus.load_ready;

  assign bus.s_out = s_out_q;
  assign bus.busy  = (state_q != StIdle);
  assign bus.done  = (state_q == StStop);

  // Parity rides at the tail of the shift register so it pops out right after the last data bit.
  always_comb begin
    if (LSB_FIRST) begin
      load_word = {^bus.data_in, bus.data_in};
      shifted   = {1'b0, shreg_q[WIDTH:1]};
      out_bit   = shreg_q[0];
    end else begin
      load_word = {bus.data_in, ^bus.data_in};
      shifted   = {shreg_q[WIDTH-1:0], 1'b0};
      out_bit   = shreg_q[WIDTH];
    end
  end

  // s_out_d is the level of the cycle after the edge, keeping s_out purely registered.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shreg_d = shreg_q;
    s_out_d = IDLE_LEVEL;

    case (state_q)
      StIdle: begin
        if (handshake) begin
          state_d = StStart;
          shreg_d = load_word;
          s_out_d = START_LEVEL;
        end
      end
      StStart: begin
        state_d = StData;
        cnt_d   = '0;
        shreg_d = shifted;
        s_out_d = out_bit;
      end
      StData: begin
        if (cnt_q == CntLast) begin
          if (PARITY_EN) begin
            state_d = StParity;
            s_out_d = out_bit;
          end else begin
            state_d = StStop;
            s_out_d = STOP_LEVEL;
          end
        end else begin
          cnt_d   = cnt_q + 1'b1;
          shreg_d = shifted;
          s_out_d = out_bit;
        end
      end
      StParity: begin
        state_d = StStop;
        s_out_d = STOP_LEVEL;
      end
      StStop: begin
        if (handshake) begin
          state_d = StStart;
          shreg_d = load_word;
          s_out_d = START_LEVEL;
        end else begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      shreg_q <= '0;
      s_out_q <= IDLE_LEVEL;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shreg_q <= shreg_d;
      s_out_q <= s_out_d;
    end
  end

endmodule

// File: tb/tb_piso_frame_tx.sv
// Bench for piso_frame_tx: three configurations checked against a frame-level bit model.
module tb_piso_frame_tx;

  localparam bit LSB_CFG [3] = '{1'b1, 1'b0, 1'b1};
  localparam bit PAR_CFG [3] = '{1'b1, 1'b1, 1'b0};

  logic clk = 1'b0;
  logic clear;

  logic [7:0] data_drv  [3];
  logic       valid_drv [3];
  logic [3:0] obs       [3];  // {s_out, busy, done, load_ready}

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  piso_frame_tx_if #(.WIDTH(8)) if_a ();
  piso_frame_tx_if #(.WIDTH(8)) if_b ();
  piso_frame_tx_if #(.WIDTH(8)) if_c ();

  assign if_a.data_in    = data_drv[0];
  assign if_a.load_valid = valid_drv[0];
  assign if_b.data_in    = data_drv[1];
  assign if_b.load_valid = valid_drv[1];
  assign if_c.data_in    = data_drv[2];
  assign if_c.load_valid = valid_drv[2];

  assign obs[0] = {if_a.s_out, if_a.busy, if_a.done, if_a.load_ready};
  assign obs[1] = {if_b.s_out, if_b.busy, if_b.done, if_b.load_ready};
  assign obs[2] = {if_c.s_out, if_c.busy, if_c.done, if_c.load_ready};

  piso_frame_tx #(.WIDTH(8), .LSB_FIRST(1'b1), .PARITY_EN(1'b1)) u_dut_a (
    .clk  (clk),
    .clear(clear),
    .bus  (if_a)
  );

  piso_frame_tx #(.WIDTH(8), .LSB_FIRST(1'b0), .PARITY_EN(1'b1)) u_dut_b (
    .clk  (clk),
    .clear(clear),
    .bus  (if_b)
  );

  piso_frame_tx #(.WIDTH(8), .LSB_FIRST(1'b1), .PARITY_EN(1'b0)) u_dut_c (
    .clk  (clk),
    .clear(clear),
    .bus  (if_c)
  );

  function automatic int frame_len(input int d);
    return PAR_CFG[d] ? 11 : 10;
  endfunction

  // Line level at position i of a frame carrying word w.
  function automatic logic frame_bit(input int d, input logic [7:0] w, input int i);
    if (i == 0) return 1'b1;
    if (i <= 8) return LSB_CFG[d] ? w[i-1] : w[8-i];
    if (i == frame_len(d) - 1) return 1'b0;
    return ^w;
  endfunction

  // Sends nfr frames (w0, then w1) with load_valid held; wiggle scrambles data_in mid-frame.
  task automatic run_stream(input int d, input logic [7:0] w0, input logic [7:0] w1,
                            input int nfr, input bit wiggle, input string name);
    int         len;
    int         fi;
    int         bi;
    logic [7:0] w;
    logic [3:0] exp;
    len = frame_len(d);
    @(negedge clk);
    data_drv[d]  = w0;
    valid_drv[d] = 1'b1;
    n_cmp++;
    if (obs[d] !== 4'b0001) begin
      n_fail++;
      $display("FAIL %s pre-load: got s/b/d/r=%b want 0001", name, obs[d]);
    end
    @(negedge clk);
    if (nfr == 2) data_drv[d] = w1;
    else if (!wiggle) valid_drv[d] = 1'b0;
    for (int i = 0; i < nfr * len; i++) begin
      fi  = i / len;
      bi  = i % len;
      w   = (fi == 0) ? w0 : w1;
      exp = {frame_bit(d, w, bi), 1'b1, (bi == len - 1), (bi == len - 1)};
      n_cmp++;
      if (obs[d] !== exp) begin
        n_fail++;
        $display("FAIL %s cycle %0d: got s/b/d/r=%b want %b", name, i, obs[d], exp);
      end
      if (bi == len - 1) begin
        if (fi == nfr - 1) valid_drv[d] = 1'b0;
      end else begin
        if (wiggle) data_drv[d] = 8'($urandom);
        if (bi == len - 2 && fi < nfr - 1) data_drv[d] = w1;
      end
      @(negedge clk);
    end
    n_cmp++;
    if (obs[d] !== 4'b0001) begin
      n_fail++;
      $display("FAIL %s idle-after: got s/b/d/r=%b want 0001", name, obs[d]);
    end
  endtask

  task automatic test_reset();
    clear = 1'b1;
    for (int d = 0; d < 3; d++) begin
      valid_drv[d] = 1'b1;
      data_drv[d]  = 8'($urandom);
    end
    repeat (3) @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      n_cmp++;
      if (obs[d] !== 4'b0000) begin
        n_fail++;
        $display("FAIL reset dut%0d: got s/b/d/r=%b want 0000", d, obs[d]);
      end
      valid_drv[d] = 1'b0;
    end
    clear = 1'b0;
    #1;
    for (int d = 0; d < 3; d++) begin
      n_cmp++;
      if (obs[d] !== 4'b0001) begin
        n_fail++;
        $display("FAIL reset-release dut%0d: got s/b/d/r=%b want 0001", d, obs[d]);
      end
    end
  endtask

  task automatic test_basic();
    run_stream(0, 8'hA5, 8'h00, 1, 1'b0, "lsb_a5");
    run_stream(1, 8'h01, 8'h00, 1, 1'b0, "msb_01");
    run_stream(2, 8'hFF, 8'h00, 1, 1'b0, "nopar_ff");
  endtask

  task automatic test_back_to_back();
    run_stream(0, 8'h0F, 8'hF0, 2, 1'b0, "b2b_0f_f0");
    run_stream(1, 8'h81, 8'h7E, 2, 1'b0, "b2b_msb");
  endtask

  task automatic test_midframe_change();
    run_stream(0, 8'h5A, 8'h00, 1, 1'b1, "wiggle_a");
    run_stream(1, 8'hC3, 8'h00, 1, 1'b1, "wiggle_b");
  endtask

  task automatic test_clear_mid();
    logic [7:0] w;
    w = 8'($urandom);
    @(negedge clk);
    data_drv[0]  = w;
    valid_drv[0] = 1'b1;
    @(negedge clk);
    valid_drv[0] = 1'b0;
    repeat (4) @(negedge clk);
    n_cmp++;
    if (obs[0] !== {frame_bit(0, w, 4), 3'b100}) begin
      n_fail++;
      $display("FAIL clear pre-check: got s/b/d/r=%b want %b", obs[0], {frame_bit(0, w, 4), 3'b100});
    end
    clear = 1'b1;
    #1;
    n_cmp++;
    if (obs[0] !== 4'b0000) begin
      n_fail++;
      $display("FAIL clear immediate: got s/b/d/r=%b want 0000", obs[0]);
    end
    @(negedge clk);
    clear = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_cmp++;
      if (obs[0] !== 4'b0001) begin
        n_fail++;
        $display("FAIL clear no-resume %0d: got s/b/d/r=%b want 0001", i, obs[0]);
      end
      @(negedge clk);
    end
    run_stream(0, 8'h3C, 8'h00, 1, 1'b0, "post_clear_3c");
  endtask

  task automatic test_random();
    int         d;
    int         nfr;
    bit         wig;
    logic [7:0] w0;
    logic [7:0] w1;
    for (int k = 0; k < 12; k++) begin
      d   = int'($urandom_range(0, 2));
      nfr = int'($urandom_range(1, 2));
      wig = 1'($urandom);
      w0  = 8'($urandom);
      w1  = 8'($urandom);
      run_stream(d, w0, w1, nfr, wig, $sformatf("rand%0d_dut%0d", k, d));
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
  endtask

  initial begin
    for (int d = 0; d < 3; d++) begin
      data_drv[d]  = 8'h00;
      valid_drv[d] = 1'b0;
    end
    test_reset();
    test_basic();
    test_back_to_back();
    test_midframe_change();
    test_clear_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
